mem_bist_engine: RTL and testbench
==================================

Name: mem_bist_engine

Overview:
- Parametrised March-test BIST engine placed in front of the MEMCTRL SRAM port. It replaces the fixed single-mode BIST with width, depth and read-latency parameters, four selectable algorithms, failure counting and first-fail capture.
- While a test runs it owns the memory chip-select, write-enable, output-enable, address and write-data lines.
- The MEMCTRL mux selects between functional traffic and this engine using BIST_BUSY.

Parameters:
- AW, 16: memory address width.
- DW, 8: memory data width.
- DEPTH, 2**AW: number of words tested, addresses 0..DEPTH-1. Legal range 2..2**AW.
- READ_LAT, 1: cycles from a read-issue cycle to valid MEM_RDATA. Legal range 1..4.
- CNTW, 8: width of the failure counter, which saturates.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset, synchronous and active-high.
- BIST_EN  in  1  level: high starts and holds a run; low aborts or releases.
- BIST_MODE  in  3  algorithm select, latched at start.
- MEM_CSB  out  1  chip select, active-low.
- MEM_WEB  out  1  write enable, active-low.
- MEM_OEB  out  1  output enable, active-low.
- MEM_ADDR  out  AW  word address.
- MEM_WDATA  out  DW  write data.
- MEM_RDATA  in  DW  read data, valid READ_LAT cycles after the read-issue cycle.
- BIST_BUSY  out  1  engine owns the memory port.
- BIST_DONE  out  1  run complete; held high until BIST_EN falls.
- BIST_PASS  out  1  valid while DONE: 1 means zero mismatches and a legal mode.
- MODE_ERR  out  1  illegal BIST_MODE was latched.
- FAIL_CNT  out  CNTW  mismatch count, saturating at all-ones.
- FAIL_ADDR  out  AW  address of the first mismatch.
- FAIL_DATA  out  DW  read data of the first mismatch.

Behaviour:
- Reset:
  - State is IDLE.
  - MEM_CSB, MEM_WEB and MEM_OEB are 1.
  - MEM_ADDR and MEM_WDATA are 0.
  - BUSY, DONE, PASS, MODE_ERR, FAIL_CNT, FAIL_ADDR and FAIL_DATA are 0.
  - RST overrides every other event in the same cycle.
- Modes. Backgrounds: B0 is all-zeros, B1 is all-ones.
  - 001 March C-: ⇕w0; ⇑(r0,w1); ⇑(r1,w0); ⇓(r0,w1); ⇓(r1,w0); ⇕r0. That is 10 ops per word. The ⇕ elements run ascending.
  - 010 MATS+: ⇕w0; ⇑(r0,w1); ⇓(r1,w0). That is 5 ops per word.
  - 011 Checkerboard: ⇑wP; ⇑rP; ⇑w~P; ⇑r~P, where P = 0x55.. at even addresses and 0xAA.. at odd addresses. That is 4 ops per word.
  - 100 March X: ⇕w0; ⇑(r0,w1); ⇓(r1,w0); ⇕r0. That is 6 ops per word.
  - Any other value is illegal.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when BIST_EN=1 and the mode is legal. On this transition: latch mode; clear FAIL_CNT, FAIL_ADDR, FAIL_DATA and MODE_ERR; set BUSY.
  - IDLE → DONE when BIST_EN=1 and the mode is illegal. Set MODE_ERR=1 and PASS=0; issue no memory access.
  - RUN issues exactly one op per cycle, with no bubbles:
    - Within an element, all ops for an address run before the address steps.
    - ⇑ runs 0..DEPTH-1; ⇓ runs DEPTH-1..0.
    - Write: CSB=0, WEB=0, OEB=1.
    - Read: CSB=0, WEB=1, OEB=0.
    - The first op drives the port in the cycle after the start edge.
  - RUN → DRAIN after the last op. DRAIN holds the port idle (CSB=1) for READ_LAT cycles.
  - DRAIN → DONE. On entry: BUSY=0, DONE=1, PASS = (FAIL_CNT==0).
  - DONE → IDLE when BIST_EN=0. DONE and PASS clear; FAIL_* and MODE_ERR hold until the next start.
- Read comparison:
  - Expected data and address are pipelined by READ_LAT cycles alongside each read.
  - MEM_RDATA is compared READ_LAT cycles after the issue cycle.
  - A mismatch increments FAIL_CNT, saturating.
  - On the first mismatch only, FAIL_ADDR and FAIL_DATA are captured.
- Latency: DONE rises exactly ops×DEPTH + READ_LAT + 1 cycles after the start edge.
- Abort: BIST_EN=0 during RUN or DRAIN moves to IDLE next cycle.
  - Port goes idle, BUSY=0, DONE=0, PASS=0.
  - In-flight compares are discarded.
- Boundaries:
  - BIST_MODE changes during RUN are ignored.
  - A mismatch in the last read of a run is counted before DONE rises.
  - The address counter never exceeds DEPTH-1 and never wraps past 0.

Decomposition:
- Package mem_bist_pkg holds:
  - mode constants;
  - op encoding (R/W, data polarity);
  - direction encoding;
  - per-mode March element tables (element count, ops per element, direction);
  - the checkerboard pattern function.
- One sub-module, mem_bist_cmp: the READ_LAT-deep expected-data/address pipeline plus compare, count and first-fail capture.

Test Plan:
- Fault-free model, DEPTH=16, READ_LAT=1, mode 001 → DONE exactly 162 cycles after start; PASS=1; FAIL_CNT=0; 160 port ops, with addresses descending in elements 4 and 5.
- Model with address 5 bit 0 stuck-at-1, mode 010, DEPTH=16 → PASS=0; FAIL_ADDR=5; FAIL_DATA=0x01; FAIL_CNT=1 (the r0 in element 2).
- Model with address 3 bit 7 stuck-at-0, mode 011, READ_LAT=3 → FAIL_CNT=1, FAIL_ADDR=3, FAIL_DATA=0x2A; DONE at 4×16+4 = 68 cycles.
- BIST_MODE=3'b111 → DONE on the next cycle; MODE_ERR=1; PASS=0; MEM_CSB held at 1 throughout.
- BIST_EN dropped 20 cycles into a mode 001 run → IDLE next cycle; BUSY=0, DONE=0, CSB=1. A restart then runs the full 162 cycles with counters cleared.
- Whole-array stuck-at-0 on bit 0, CNTW=4, mode 001 → FAIL_CNT saturates at 15; FAIL_ADDR=0; PASS=0.

Source files
------------

// File: rtl/mem_bist_pkg.sv
// Shared encodings and March element tables for the memory BIST engine.
// Each algorithm is described as a list of elements (direction, op count, ops).
package mem_bist_pkg;

  localparam logic [2:0] MODE_MARCH_CM = 3'b001;
  localparam logic [2:0] MODE_MATS_P   = 3'b010;
  localparam logic [2:0] MODE_CKBD     = 3'b011;
  localparam logic [2:0] MODE_MARCH_X  = 3'b100;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

  // inv selects the inverted background (all-ones, or ~P for checkerboard)
  typedef struct packed {
    logic wr;
    logic inv;
  } bist_op_t;

  localparam bist_op_t OP_W0 = '{wr: 1'b1, inv: 1'b0};
  localparam bist_op_t OP_W1 = '{wr: 1'b1, inv: 1'b1};
  localparam bist_op_t OP_R0 = '{wr: 1'b0, inv: 1'b0};
  localparam bist_op_t OP_R1 = '{wr: 1'b0, inv: 1'b1};

  function automatic logic mode_legal(input logic [2:0] m);
    mode_legal = (m == MODE_MARCH_CM) || (m == MODE_MATS_P) ||
                 (m == MODE_CKBD) || (m == MODE_MARCH_X);
  endfunction

  function automatic logic [2:0] num_elems(input logic [2:0] m);
    num_elems = 3'd1;
    case (m)
      MODE_MARCH_CM: num_elems = 3'd6;
      MODE_MATS_P:   num_elems = 3'd3;
      MODE_CKBD:     num_elems = 3'd4;
      MODE_MARCH_X:  num_elems = 3'd4;
      default:       num_elems = 3'd1;
    endcase
  endfunction

  function automatic logic elem_dir(input logic [2:0] m, input logic [2:0] e);
    elem_dir = DIR_UP;
    case (m)
      MODE_MARCH_CM: if (e == 3'd3 || e == 3'd4) elem_dir = DIR_DN;
      MODE_MATS_P:   if (e == 3'd2) elem_dir = DIR_DN;
      MODE_MARCH_X:  if (e == 3'd2) elem_dir = DIR_DN;
      default:       elem_dir = DIR_UP;
    endcase
  endfunction

  function automatic logic [1:0] elem_nops(input logic [2:0] m, input logic [2:0] e);
    elem_nops = 2'd1;
    case (m)
      MODE_MARCH_CM: if (e >= 3'd1 && e <= 3'd4) elem_nops = 2'd2;
      MODE_MATS_P:   if (e == 3'd1 || e == 3'd2) elem_nops = 2'd2;
      MODE_MARCH_X:  if (e == 3'd1 || e == 3'd2) elem_nops = 2'd2;
      default:       elem_nops = 2'd1;
    endcase
  endfunction

  function automatic bist_op_t elem_op(input logic [2:0] m, input logic [2:0] e,
                                       input logic k);
    elem_op = OP_R0;
    case (m)
      MODE_MARCH_CM:
        case (e)
          3'd0:    elem_op = OP_W0;
          3'd1:    elem_op = k ? OP_W1 : OP_R0;
          3'd2:    elem_op = k ? OP_W0 : OP_R1;
          3'd3:    elem_op = k ? OP_W1 : OP_R0;
          3'd4:    elem_op = k ? OP_W0 : OP_R1;
          default: elem_op = OP_R0;
        endcase
      MODE_MATS_P:
        case (e)
          3'd0:    elem_op = OP_W0;
          3'd1:    elem_op = k ? OP_W1 : OP_R0;
          default: elem_op = k ? OP_W0 : OP_R1;
        endcase
      MODE_CKBD:
        case (e)
          3'd0:    elem_op = OP_W0;
          3'd1:    elem_op = OP_R0;
          3'd2:    elem_op = OP_W1;
          default: elem_op = OP_R1;
        endcase
      MODE_MARCH_X:
        case (e)
          3'd0:    elem_op = OP_W0;
          3'd1:    elem_op = k ? OP_W1 : OP_R0;
          3'd2:    elem_op = k ? OP_W0 : OP_R1;
          default: elem_op = OP_R0;
        endcase
      default: elem_op = OP_R0;
    endcase
  endfunction

  // P is 0x55.. at even addresses, 0xAA.. at odd addresses
  function automatic logic ckbd_bit(input logic addr_lsb, input logic bit_odd);
    ckbd_bit = ~(addr_lsb ^ bit_odd);
  endfunction

endpackage

// File: rtl/mem_bist_cmp.sv
// Read-compare path: expected data/address travel READ_LAT stages alongside each
// read, then mismatches are counted (saturating) and the first one is captured.
module mem_bist_cmp
  import mem_bist_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int READ_LAT = 1,
  parameter int CNTW     = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            flush,
  input  logic            issue,
  input  logic [DW-1:0]   exp_data,
  input  logic [AW-1:0]   exp_addr,
  input  logic [DW-1:0]   rdata,
  output logic [CNTW-1:0] fail_cnt,
  output logic [AW-1:0]   fail_addr,
  output logic [DW-1:0]   fail_data
);

  logic [READ_LAT:1]         vld_pipe;
  logic [READ_LAT:1][DW-1:0] exp_pipe;
  logic [READ_LAT:1][AW-1:0] addr_pipe;
  logic                      miss;

  assign miss = vld_pipe[READ_LAT] && (rdata != exp_pipe[READ_LAT]);

  always_ff @(posedge clk) begin
    exp_pipe[1]  <= exp_data;
    addr_pipe[1] <= exp_addr;
    for (int i = 2; i <= READ_LAT; i++) begin
      exp_pipe[i]  <= exp_pipe[i-1];
      addr_pipe[i] <= addr_pipe[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      vld_pipe  <= '0;
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_data <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= issue;
      for (int i = 2; i <= READ_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
      if (miss) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        // a zero count marks the first mismatch; saturation never returns to zero
        if (fail_cnt == '0) begin
          fail_addr <= addr_pipe[READ_LAT];
          fail_data <= rdata;
        end
      end
    end
  end

endmodule

// File: rtl/mem_bist_engine.sv
// March-test BIST sequencer owning the SRAM port while a run is active.
// One op per RUN cycle; a drain window lets the last read settle before DONE.
module mem_bist_engine
  import mem_bist_pkg::*;
#(
  parameter int AW       = 16,
  parameter int DW       = 8,
  parameter int DEPTH    = 2**AW,
  parameter int READ_LAT = 1,
  parameter int CNTW     = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            BIST_EN,
  input  logic [2:0]      BIST_MODE,
  output logic            MEM_CSB,
  output logic            MEM_WEB,
  output logic            MEM_OEB,
  output logic [AW-1:0]   MEM_ADDR,
  output logic [DW-1:0]   MEM_WDATA,
  input  logic [DW-1:0]   MEM_RDATA,
  output logic            BIST_BUSY,
  output logic            BIST_DONE,
  output logic            BIST_PASS,
  output logic            MODE_ERR,
  output logic [CNTW-1:0] FAIL_CNT,
  output logic [AW-1:0]   FAIL_ADDR,
  output logic [DW-1:0]   FAIL_DATA
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam int            DCW       = $clog2(READ_LAT + 1);

  logic [1:0]     state;
  logic [2:0]     mode_q;
  logic [2:0]     elem;
  logic           opi;
  logic [AW-1:0]  addr;
  logic [DCW-1:0] drain_cnt;
  logic           busy_q, done_q, pass_q, mode_err_q;

  bist_op_t      op;
  logic          run, cur_dir, last_op, addr_end, last_elem;
  logic [DW-1:0] pat, data;

  assign run       = (state == ST_RUN);
  assign op        = elem_op(mode_q, elem, opi);
  assign cur_dir   = elem_dir(mode_q, elem);
  assign last_op   = ({1'b0, opi} == elem_nops(mode_q, elem) - 2'd1);
  assign addr_end  = (cur_dir == DIR_DN) ? (addr == '0) : (addr == LAST_ADDR);
  assign last_elem = (elem == num_elems(mode_q) - 3'd1);

  for (genvar i = 0; i < DW; i++) begin : g_pat
    assign pat[i] = (mode_q == MODE_CKBD) & ckbd_bit(addr[0], (i % 2) == 1);
  end
  assign data = pat ^ {DW{op.inv}};

  assign MEM_CSB   = ~run;
  assign MEM_WEB   = ~(run & op.wr);
  assign MEM_OEB   = ~(run & ~op.wr);
  assign MEM_ADDR  = run ? addr : '0;
  assign MEM_WDATA = (run & op.wr) ? data : '0;

  assign BIST_BUSY = busy_q;
  assign BIST_DONE = done_q;
  assign BIST_PASS = pass_q;
  assign MODE_ERR  = mode_err_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      elem       <= '0;
      opi        <= 1'b0;
      addr       <= '0;
      drain_cnt  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      mode_err_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (BIST_EN) begin
          mode_q <= BIST_MODE;
          elem   <= '0;
          opi    <= 1'b0;
          if (mode_legal(BIST_MODE)) begin
            state      <= ST_RUN;
            busy_q     <= 1'b1;
            mode_err_q <= 1'b0;
            addr       <= (elem_dir(BIST_MODE, 3'd0) == DIR_DN) ? LAST_ADDR : '0;
          end else begin
            state      <= ST_DONE;
            done_q     <= 1'b1;
            pass_q     <= 1'b0;
            mode_err_q <= 1'b1;
          end
        end
        ST_RUN: if (!BIST_EN) begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end else if (!last_op) begin
          opi <= 1'b1;
        end else begin
          opi <= 1'b0;
          if (!addr_end) begin
            addr <= (cur_dir == DIR_DN) ? addr - 1'b1 : addr + 1'b1;
          end else if (last_elem) begin
            state     <= ST_DRAIN;
            drain_cnt <= DCW'(READ_LAT);
          end else begin
            elem <= elem + 3'd1;
            addr <= (elem_dir(mode_q, elem + 3'd1) == DIR_DN) ? LAST_ADDR : '0;
          end
        end
        // one cycle past READ_LAT so the final compare is in FAIL_CNT before PASS samples it
        ST_DRAIN: if (!BIST_EN) begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end else if (drain_cnt == '0) begin
          state  <= ST_DONE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          pass_q <= (FAIL_CNT == '0);
        end else begin
          drain_cnt <= drain_cnt - 1'b1;
        end
        ST_DONE: if (!BIST_EN) begin
          state  <= ST_IDLE;
          done_q <= 1'b0;
          pass_q <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  mem_bist_cmp #(
    .AW(AW), .DW(DW), .READ_LAT(READ_LAT), .CNTW(CNTW)
  ) u_cmp (
    .clk       (CLK),
    .rst       (RST),
    .clr       ((state == ST_IDLE) && BIST_EN),
    .flush     (((state == ST_RUN) || (state == ST_DRAIN)) && !BIST_EN),
    .issue     (run && !op.wr),
    .exp_data  (data),
    .exp_addr  (addr),
    .rdata     (MEM_RDATA),
    .fail_cnt  (FAIL_CNT),
    .fail_addr (FAIL_ADDR),
    .fail_data (FAIL_DATA)
  );

endmodule

// File: tb/tb_mem_bist_engine.sv
// Directed bench: three engines (RL=1, RL=3, CNTW=4) on 16-word memories with
// injectable stuck-at faults; March C- port traffic is checked against a sequence model.
module tb_mem_bist_engine;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            RST;
  logic [2:0]      en;
  logic [2:0][2:0] mode;
  logic [2:0]      csb, web, oeb, busy, done, pass, merr;
  logic [2:0][7:0] maddr, wdata, fcnt, faddr, fdata;

  logic [7:0] sa1_mask [3];
  logic [7:0] sa0_mask [3];
  int         sa1_addr [3];
  int         sa0_addr [3];   // -1 applies the stuck-at-0 mask to every word

  int n_chk  = 0;
  int n_fail = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int RL = (g == 1) ? 3 : 1;
    localparam int CW = (g == 2) ? 4 : 8;
    logic [7:0]    mem   [16];
    logic [7:0]    rpipe [RL];
    logic [7:0]    rv;
    logic [CW-1:0] cnt;

    mem_bist_engine #(
      .AW(8), .DW(8), .DEPTH(16), .READ_LAT(RL), .CNTW(CW)
    ) u_dut (
      .CLK(CLK), .RST(RST), .BIST_EN(en[g]), .BIST_MODE(mode[g]),
      .MEM_CSB(csb[g]), .MEM_WEB(web[g]), .MEM_OEB(oeb[g]),
      .MEM_ADDR(maddr[g]), .MEM_WDATA(wdata[g]), .MEM_RDATA(rpipe[RL-1]),
      .BIST_BUSY(busy[g]), .BIST_DONE(done[g]), .BIST_PASS(pass[g]),
      .MODE_ERR(merr[g]), .FAIL_CNT(cnt), .FAIL_ADDR(faddr[g]),
      .FAIL_DATA(fdata[g])
    );
    assign fcnt[g] = 8'(cnt);

    always @(posedge CLK) begin
      if (!csb[g] && !web[g]) mem[maddr[g][3:0]] <= wdata[g];
      rv = mem[maddr[g][3:0]];
      if (sa0_addr[g] < 0 || sa0_addr[g] == int'(maddr[g])) rv = rv & ~sa0_mask[g];
      if (sa1_addr[g] == int'(maddr[g])) rv = rv | sa1_mask[g];
      rpipe[0] <= (!csb[g] && !oeb[g]) ? rv : 8'h5A;
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
  end

  typedef struct packed {
    logic       web;
    logic [7:0] addr;
    logic [7:0] wdata;
  } op_t;
  op_t mon_q[$];

  always @(posedge CLK) if (!csb[0]) mon_q.push_back('{web[0], maddr[0], wdata[0]});

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Starts a run, scrambles BIST_MODE mid-run, and returns edges from start to DONE.
  task automatic start_run(input int g, input logic [2:0] m, output int edges,
                           output logic busy_seen);
    @(negedge CLK);
    mode[g] = m;
    en[g]   = 1'b1;
    @(posedge CLK); #1;
    busy_seen = busy[g];
    edges     = 0;
    @(negedge CLK);
    mode[g] = 3'b111;
    while (!done[g] && edges < 2000) begin
      @(posedge CLK); #1;
      edges++;
    end
    chk("done_reached", done[g], 1'b1);
  endtask

  task automatic stop_run(input int g);
    @(negedge CLK);
    en[g] = 1'b0;
    @(posedge CLK); #1;
  endtask

  // Independent March C- model over 16 words: returns number of port-op differences.
  task automatic check_marchc_seq(output int nbad);
    int  nops   [6] = '{1, 2, 2, 2, 2, 1};
    bit  dn     [6] = '{0, 0, 0, 1, 1, 0};
    bit  op_wr  [6][2] = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
    bit  op_inv [6][2] = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};
    int  n = 0;
    op_t o;
    nbad = 0;
    for (int e = 0; e < 6; e++)
      for (int j = 0; j < 16; j++)
        for (int k = 0; k < nops[e]; k++) begin
          if (n >= mon_q.size()) begin
            nbad++;
          end else begin
            o = mon_q[n];
            if (o.web !== !op_wr[e][k]) nbad++;
            else if (o.addr !== 8'(dn[e] ? 15 - j : j)) nbad++;
            else if (op_wr[e][k] && o.wdata !== (op_inv[e][k] ? 8'hFF : 8'h00)) nbad++;
          end
          n++;
        end
    if (mon_q.size() != n) nbad++;
  endtask

  int   edges, nbad;
  logic bsy;

  initial begin
    RST  = 1'b1;
    en   = '0;
    mode = '0;
    for (int g = 0; g < 3; g++) begin
      sa1_mask[g] = 8'h00; sa0_mask[g] = 8'h00;
      sa1_addr[g] = -2;    sa0_addr[g] = -2;
    end
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_csb", csb[0], 1'b1);
    chk("rst_web", web[0], 1'b1);
    chk("rst_oeb", oeb[0], 1'b1);
    chk("rst_addr", maddr[0], 8'h00);
    chk("rst_wdata", wdata[0], 8'h00);
    chk("rst_busy", busy[0], 1'b0);
    chk("rst_done", done[0], 1'b0);
    chk("rst_pass", pass[0], 1'b0);
    chk("rst_merr", merr[0], 1'b0);
    chk("rst_fcnt", fcnt[0], 8'h00);
    chk("rst_faddr", faddr[0], 8'h00);
    chk("rst_fdata", fdata[0], 8'h00);
    chk("rst_csb_all", csb, 3'b111);
    @(negedge CLK);
    RST = 1'b0;

    // March C-, fault-free, READ_LAT=1
    mon_q.delete();
    start_run(0, 3'b001, edges, bsy);
    chk("mc_done_edges", edges, 162);
    chk("mc_busy_start", bsy, 1'b1);
    chk("mc_busy_end", busy[0], 1'b0);
    chk("mc_pass", pass[0], 1'b1);
    chk("mc_fcnt", fcnt[0], 8'h00);
    chk("mc_ops", mon_q.size(), 160);
    check_marchc_seq(nbad);
    chk("mc_seq_bad", nbad, 0);
    if (mon_q.size() > 82) begin
      chk("mc_e4_addr0", mon_q[80].addr, 8'd15);
      chk("mc_e4_addr1", mon_q[82].addr, 8'd14);
    end else begin
      chk("mc_e4_short", mon_q.size(), 160);
    end
    stop_run(0);
    chk("mc_rel_done", done[0], 1'b0);
    chk("mc_rel_pass", pass[0], 1'b0);

    // MATS+, address 5 bit 0 stuck-at-1
    sa1_addr[0] = 5; sa1_mask[0] = 8'h01;
    start_run(0, 3'b010, edges, bsy);
    chk("mats_done_edges", edges, 82);
    chk("mats_pass", pass[0], 1'b0);
    chk("mats_fcnt", fcnt[0], 8'd1);
    chk("mats_faddr", faddr[0], 8'd5);
    chk("mats_fdata", fdata[0], 8'h01);
    stop_run(0);
    chk("mats_hold_fcnt", fcnt[0], 8'd1);
    chk("mats_hold_faddr", faddr[0], 8'd5);
    sa1_addr[0] = -2; sa1_mask[0] = 8'h00;

    // Illegal mode: immediate DONE, no port activity
    mon_q.delete();
    start_run(0, 3'b111, edges, bsy);
    chk("merr_done_edges", edges, 0);
    chk("merr_flag", merr[0], 1'b1);
    chk("merr_pass", pass[0], 1'b0);
    chk("merr_busy", bsy, 1'b0);
    chk("merr_fcnt_clr", fcnt[0], 8'h00);
    repeat (3) @(posedge CLK);
    #1;
    chk("merr_no_ops", mon_q.size(), 0);
    stop_run(0);
    chk("merr_rel_done", done[0], 1'b0);
    chk("merr_hold_flag", merr[0], 1'b1);

    // Abort 20 cycles into March C-, then a clean restart
    mon_q.delete();
    @(negedge CLK);
    mode[0] = 3'b001;
    en[0]   = 1'b1;
    repeat (20) @(posedge CLK);
    @(negedge CLK);
    en[0] = 1'b0;
    @(posedge CLK); #1;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_done", done[0], 1'b0);
    chk("abort_pass", pass[0], 1'b0);
    chk("abort_csb", csb[0], 1'b1);
    chk("abort_ops", mon_q.size(), 20);
    repeat (2) @(posedge CLK);
    #1;
    chk("abort_idle_csb", csb[0], 1'b1);
    start_run(0, 3'b001, edges, bsy);
    chk("restart_edges", edges, 162);
    chk("restart_pass", pass[0], 1'b1);
    chk("restart_fcnt", fcnt[0], 8'h00);
    chk("restart_merr", merr[0], 1'b0);
    stop_run(0);

    // Checkerboard with READ_LAT=3, address 3 bit 7 stuck-at-0
    sa0_addr[1] = 3; sa0_mask[1] = 8'h80;
    start_run(1, 3'b011, edges, bsy);
    chk("ckbd_done_edges", edges, 68);
    chk("ckbd_fcnt", fcnt[1], 8'd1);
    chk("ckbd_faddr", faddr[1], 8'd3);
    chk("ckbd_fdata", fdata[1], 8'h2A);
    chk("ckbd_pass", pass[1], 1'b0);
    stop_run(1);
    sa0_addr[1] = -2; sa0_mask[1] = 8'h00;

    // March X, fault-free, READ_LAT=3
    start_run(1, 3'b100, edges, bsy);
    chk("mx_done_edges", edges, 100);
    chk("mx_pass", pass[1], 1'b1);
    chk("mx_fcnt", fcnt[1], 8'h00);
    stop_run(1);

    // Whole-array bit 0 stuck-at-0 with a 4-bit counter
    sa0_addr[2] = -1; sa0_mask[2] = 8'h01;
    start_run(2, 3'b001, edges, bsy);
    chk("sat_done_edges", edges, 162);
    chk("sat_fcnt", fcnt[2], 8'd15);
    chk("sat_faddr", faddr[2], 8'd0);
    chk("sat_fdata", fdata[2], 8'hFE);
    chk("sat_pass", pass[2], 1'b0);
    stop_run(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
